// File: rtl/fft_stage_sequencer.sv
// Address sequencer for an in-place radix-2 DIT FFT driving one pipelined BFU.
// Issues A/B read and twiddle addresses per butterfly and replays them as write-back addresses PIPE clocks later.
module fft_stage_sequencer #(
    parameter int unsigned LOG2N   = 3,
    parameter int unsigned BFU_LAT = 3,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic                       rd_en,
    output logic [LOG2N-1:0]           rd_addr_a,
    output logic [LOG2N-1:0]           rd_addr_b,
    output logic [LOG2N-2:0]           tw_addr,
    output logic                       wr_en,
    output logic [LOG2N-1:0]           wr_addr_a,
    output logic [LOG2N-1:0]           wr_addr_b
);

    localparam int unsigned PIPE = RAM_LAT + BFU_LAT;
    localparam int unsigned HALF = 1 << (LOG2N - 1);
    localparam int unsigned STW  = $clog2(LOG2N);
    localparam int unsigned KW   = LOG2N - 1;
    localparam int unsigned TWW  = LOG2N - 1;
    localparam int unsigned DW   = $clog2(PIPE + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic [STW-1:0]   stage_nxt;
    logic [DW-1:0]    drain_cnt, drain_nxt;

    logic [LOG2N-1:0] kx, span, pos, addr_a, addr_b;
    logic [TWW-1:0]   tw;
    logic             rd_en_nxt, busy_nxt, done_nxt;

    logic [PIPE-1:0]  vld_sr;
    logic [LOG2N-1:0] a_sr [PIPE];
    logic [LOG2N-1:0] b_sr [PIPE];

    // State, counters and issue-side outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE;
            k         <= '0;
            stage     <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            stage     <= stage_nxt;
            drain_cnt <= drain_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            rd_en     <= rd_en_nxt;
            rd_addr_a <= addr_a;
            rd_addr_b <= addr_b;
            tw_addr   <= tw;
        end
    end

    // Next state plus registered-output precompute from the next-cycle counters
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        stage_nxt = stage;
        drain_nxt = drain_cnt;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                    k_nxt     = '0;
                    stage_nxt = '0;
                end
            end
            S_ISSUE: begin
                if (k == KW'(HALF - 1)) begin
                    state_nxt = S_DRAIN;
                    drain_nxt = DW'(PIPE);
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DW'(1)) begin
                    if (stage == STW'(LOG2N - 1)) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_ISSUE;
                        stage_nxt = stage + STW'(1);
                        k_nxt     = '0;
                    end
                end else begin
                    drain_nxt = drain_cnt - DW'(1);
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase

        rd_en_nxt = (state_nxt == S_ISSUE);
        busy_nxt  = (state_nxt == S_ISSUE) || (state_nxt == S_DRAIN);
        done_nxt  = (state_nxt == S_FINISH);

        // Insert a zero at bit 'stage' of k to form the A index; B sits one span above
        kx     = LOG2N'(k_nxt);
        span   = LOG2N'(1) << stage_nxt;
        pos    = kx & (span - LOG2N'(1));
        addr_a = '0;
        addr_b = '0;
        tw     = '0;
        if (rd_en_nxt) begin
            addr_a = (((kx >> stage_nxt) << stage_nxt) << 1) | pos;
            addr_b = addr_a + span;
            tw     = TWW'(pos) << (STW'(LOG2N - 1) - stage_nxt);
        end
    end

    // Write-back delay line matching RAM read plus BFU latency
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vld_sr <= '0;
            for (int unsigned i = 0; i < PIPE; i++) begin
                a_sr[i] <= '0;
                b_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= rd_en;
            a_sr[0]   <= rd_addr_a;
            b_sr[0]   <= rd_addr_b;
            for (int unsigned i = 1; i < PIPE; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                a_sr[i]   <= a_sr[i-1];
                b_sr[i]   <= b_sr[i-1];
            end
        end
    end

    assign wr_en     = vld_sr[PIPE-1];
    assign wr_addr_a = a_sr[PIPE-1];
    assign wr_addr_b = b_sr[PIPE-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: N=8 directed runs with a BFU/RAM model, plus an N=16 RAM_LAT=2 instance.
module tb_fft_stage_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       start2;

    logic       busy, done, rd_en, wr_en;
    logic [1:0] stage;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr;

    logic       busy2, done2, rd_en2, wr_en2;
    logic [1:0] stage2;
    logic [3:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
    logic [2:0] tw_addr2;

    fft_stage_sequencer #(.LOG2N(3), .BFU_LAT(3), .RAM_LAT(1)) dut (
        .clk(clk), .clr(clr), .start(start), .busy(busy), .done(done), .stage(stage),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    fft_stage_sequencer #(.LOG2N(4), .BFU_LAT(3), .RAM_LAT(2)) dut16 (
        .clk(clk), .clr(clr), .start(start2), .busy(busy2), .done(done2), .stage(stage2),
        .rd_en(rd_en2), .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .tw_addr(tw_addr2),
        .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    typedef struct { int cyc; int stg; int a; int b; int tw; } rd_t;
    typedef struct { int cyc; int a; int b; } wr_t;
    typedef struct { int ar; int ai; int br; int bi; } res_t;

    rd_t  rd_q[$];
    wr_t  wr_q[$];
    int   done_q[$];
    res_t pend_q[$];
    bit   mon_en = 1'b0;

    // Hand-derived N=8 butterfly order
    int exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    int tw_re [4] = '{32767, 23170, 0, -23170};
    int tw_im [4] = '{0, -23170, -32767, -23170};
    int ram_re [8];
    int ram_im [8];

    task automatic push_run(input int t0);
        for (int i = 0; i < 12; i++) begin
            rd_t r;
            wr_t w;
            r.stg = i / 4;
            r.cyc = t0 + 1 + r.stg * 8 + (i % 4);
            r.a   = exp_a[i];
            r.b   = exp_b[i];
            r.tw  = exp_tw[i];
            w.cyc = r.cyc + 4;
            w.a   = r.a;
            w.b   = r.b;
            rd_q.push_back(r);
            wr_q.push_back(w);
        end
        done_q.push_back(t0 + 25);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every presented read, write and done against the queues
    always @(negedge clk) begin : mon
        rd_t r;
        wr_t w;
        int  d;
        if (mon_en && !clr) begin
            if (rd_en) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    r = rd_q.pop_front();
                    check("rd_cycle", cyc, r.cyc);
                    check("rd_stage", int'(stage), r.stg);
                    check("rd_addr_a", int'(rd_addr_a), r.a);
                    check("rd_addr_b", int'(rd_addr_b), r.b);
                    check("tw_addr", int'(tw_addr), r.tw);
                    check("busy_issue", int'(busy), 1);
                end
            end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                check("rd_missing", 0, 1);
                void'(rd_q.pop_front());
            end
            if (wr_en) begin
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    w = wr_q.pop_front();
                    check("wr_cycle", cyc, w.cyc);
                    check("wr_addr_a", int'(wr_addr_a), w.a);
                    check("wr_addr_b", int'(wr_addr_b), w.b);
                end
            end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
                check("wr_missing", 0, 1);
                void'(wr_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d);
                    check("busy_at_done", int'(busy), 0);
                end
            end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                check("done_missing", 0, 1);
                void'(done_q.pop_front());
            end
        end
    end

    // Closed-loop RAM + BFU model; results retire at the DUT's write addresses
    always @(negedge clk) begin : bfu_model
        res_t p;
        int   ar, ai, br, bi, pr, pi, t;
        if (clr) pend_q.delete();
        else begin
            if (rd_en) begin
                ar = ram_re[rd_addr_a]; ai = ram_im[rd_addr_a];
                br = ram_re[rd_addr_b]; bi = ram_im[rd_addr_b];
                t  = int'(tw_addr);
                pr = (br * tw_re[t] - bi * tw_im[t]) >>> 15;
                pi = (br * tw_im[t] + bi * tw_re[t]) >>> 15;
                p.ar = ar + pr; p.ai = ai + pi;
                p.br = ar - pr; p.bi = ai - pi;
                pend_q.push_back(p);
            end
            if (wr_en && pend_q.size() > 0) begin
                p = pend_q.pop_front();
                ram_re[wr_addr_a] = p.ar; ram_im[wr_addr_a] = p.ai;
                ram_re[wr_addr_b] = p.br; ram_im[wr_addr_b] = p.bi;
            end
        end
    end

    // N=16, PIPE=5 instance: positional model of the issue schedule
    int  t2 = 0;
    int  i2 = 0;
    int  j2 = 0;
    int  done2_cnt = 0;
    bit  mon2_en = 1'b0;

    always @(negedge clk) begin : mon16
        if (mon2_en && !clr) begin
            if (rd_en2) begin
                if (i2 >= 32) check("rd16_extra", 1, 0);
                else begin
                    check("rd16_cycle", cyc, t2 + 1 + (i2 / 8) * 13 + (i2 % 8));
                    check("rd16_stage", int'(stage2), i2 / 8);
                    if (i2 >= 24) begin
                        check("tw16_stage3", int'(tw_addr2), i2 - 24);
                        check("rd16_a_stage3", int'(rd_addr_a2), i2 - 24);
                        check("rd16_b_stage3", int'(rd_addr_b2), i2 - 16);
                    end
                end
                i2++;
            end
            if (wr_en2) begin
                if (j2 >= 32) check("wr16_extra", 1, 0);
                else check("wr16_cycle", cyc, t2 + 6 + (j2 / 8) * 13 + (j2 % 8));
                j2++;
            end
            if (done2) begin
                check("done16_cycle", cyc, t2 + 53);
                done2_cnt++;
            end
        end
    end

    initial begin
        int t0, t1, t3, t4, wr_seen;
        clr    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ram_re[i] = 0;
            ram_im[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_addr_b", int'(rd_addr_b), 0);
        check("rst_wr_addr_b", int'(wr_addr_b), 0);
        clr    = 1'b0;
        mon_en = 1'b1;

        // Run 1, with starts during stage 1 and during FINISH that must be ignored
        @(posedge clk); #1;
        t0 = cyc;
        push_run(t0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_to(t0 + 10);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_to(t0 + 25);
        for (int i = 0; i < 8; i++) begin
            ram_re[i] = (i == 0) ? 16384 : 0;
            ram_im[i] = 0;
        end
        start = 1'b1;
        @(posedge clk); #1;

        // Run 2 begins the cycle after done and transforms an impulse
        t1 = cyc;
        push_run(t1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_to(t1 + 27);
        check("q_rd_empty", rd_q.size(), 0);
        check("q_wr_empty", wr_q.size(), 0);
        check("q_done_empty", done_q.size(), 0);
        check("busy_after_done", int'(busy), 0);
        for (int i = 0; i < 8; i++) begin
            check("fft_re", ram_re[i], 16384);
            check("fft_im", ram_im[i], 0);
        end

        // Run 3 aborted by asynchronous clr in stage 1
        t3 = cyc;
        push_run(t3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_to(t3 + 10);
        #2;
        clr    = 1'b1;
        mon_en = 1'b0;
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        #1;
        check("clr_rd_en", int'(rd_en), 0);
        check("clr_busy", int'(busy), 0);
        check("clr_stage", int'(stage), 0);
        check("clr_rd_addr_a", int'(rd_addr_a), 0);
        check("clr_rd_addr_b", int'(rd_addr_b), 0);
        check("clr_tw_addr", int'(tw_addr), 0);
        check("clr_wr_en", int'(wr_en), 0);
        @(posedge clk); #3;
        clr    = 1'b0;
        mon_en = 1'b1;
        wr_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
        end
        check("post_clr_wr_en", wr_seen, 0);
        check("post_clr_busy", int'(busy), 0);

        // Fresh run after clr
        @(posedge clk); #1;
        t4 = cyc;
        push_run(t4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_to(t4 + 27);
        check("q4_rd_empty", rd_q.size(), 0);
        check("q4_wr_empty", wr_q.size(), 0);
        check("q4_done_empty", done_q.size(), 0);

        // N=16 instance
        t2      = cyc;
        mon2_en = 1'b1;
        start2  = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        wait_to(t2 + 58);
        check("rd16_count", i2, 32);
        check("wr16_count", j2, 32);
        check("done16_count", done2_cnt, 1);
        check("busy16_after_done", int'(busy2), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
